sid_svf_multi: RTL and testbench

Time-multiplexed, parametrised SID-style state-variable filter for CHANNELS independent SID instances (e.g. stereo/dual-SID), each with VOICES voices plus one external input. Sits between the voice generators and the audio mixer. One shared multiplier datapath updates each channel's HP/BP/LP integrators once per frame. Integrators and outputs saturate instead of wrapping. Start-while-busy events are flagged on `overrun`.

---
 rtl/sid_svf_multi_if.sv | 30 +++
 rtl/sid_svf_multi.sv | 159 +++++++++++++++
 tb/tb_sid_svf_multi.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sid_svf_multi_if.sv
// sid_svf_multi_if: frame control, per-channel filter settings and audio outputs of the multi-channel SID filter
interface sid_svf_multi_if #(
  parameter int CHANNELS = 2,
  parameter int VOICES = 3,
  parameter int DW = 12,
  parameter int AW = DW + 6
);
  logic start;
  logic [CHANNELS*VOICES*DW-1:0] voice_in;
  logic [CHANNELS*DW-1:0] ext_in;
  logic [CHANNELS*11-1:0] fc;
  logic [CHANNELS*4-1:0] res;
  logic [CHANNELS*(VOICES+1)-1:0] route;
  logic [CHANNELS*3-1:0] mode;
  logic [CHANNELS-1:0] voff;
  logic [CHANNELS*4-1:0] vol;
  logic filter_en;
  logic busy;
  logic overrun;
  logic [CHANNELS*AW-1:0] sound;
  logic [CHANNELS-1:0] sound_valid;
  modport master (
    output start, voice_in, ext_in, fc, res, route, mode, voff, vol, filter_en,
    input busy, overrun, sound, sound_valid
  );
  modport slave (
    input start, voice_in, ext_in, fc, res, route, mode, voff, vol, filter_en,
    output busy, overrun, sound, sound_valid
  );
endinterface

// File: rtl/sid_svf_multi.sv
// sid_svf_multi: time-multiplexed saturating SID state-variable filter shared across several channels
module sid_svf_multi #(
  parameter int CHANNELS = 2,
  parameter int VOICES = 3,
  parameter int DW = 12,
  parameter int AW = DW + 6
) (
  input logic clk,
  input logic rst,
  sid_svf_multi_if.slave s
);
  localparam int WW = AW + 20;
  localparam int NI = VOICES + 1;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int IW = $clog2(VOICES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(VOICES);
  localparam logic [IW-1:0] I_VLAST = IW'(VOICES - 1);
  localparam logic signed [WW-1:0] S_MAX = (WW'(1) <<< (AW - 1)) - 1;
  localparam logic signed [WW-1:0] S_MIN = -S_MAX - 1;
  localparam logic signed [WW-1:0] ZW = '0;
  localparam logic [10:0] QT [16] = '{11'd1448, 11'd1328, 11'd1218, 11'd1117, 11'd1024, 11'd939,
    11'd861, 11'd790, 11'd724, 11'd664, 11'd609, 11'd558, 11'd512, 11'd470, 11'd431, 11'd395};
  typedef enum logic [2:0] {IDLE, SUM, COEF, BP, LP, HP, MIX, OUT} state_t;
  state_t state, state_n;
  logic [CW-1:0] ch;
  logic [IW-1:0] idx;
  logic [CHANNELS*VOICES*DW-1:0] voice_s;
  logic [CHANNELS*DW-1:0] ext_s;
  logic [CHANNELS*11-1:0] fc_s;
  logic [CHANNELS*4-1:0] res_s;
  logic [CHANNELS*NI-1:0] route_s;
  logic [CHANNELS*3-1:0] mode_s;
  logic [CHANNELS-1:0] voff_s;
  logic [CHANNELS*4-1:0] vol_s;
  logic fen_s;
  logic signed [AW-1:0] vhp [CHANNELS];
  logic signed [AW-1:0] vbp [CHANNELS];
  logic signed [AW-1:0] vlp [CHANNELS];
  logic signed [AW-1:0] vi, vnf, y;
  logic [16:0] w0;
  logic [10:0] q;
  logic [CHANNELS*AW-1:0] sound_r;
  logic [CHANNELS-1:0] valid_r;
  logic ovr_r;
  logic signed [DW-1:0] cur;
  logic signed [AW-1:0] xa;
  logic rt, nf_skip;
  logic [10:0] fc_c;
  logic [3:0] res_c, vol_c;
  logic [2:0] mode_c;
  logic signed [WW-1:0] w0_x, q_x, vol_x;
  logic signed [AW-1:0] bp_n, lp_n, hp_n, vf_n, y_n, snd_n;

  function automatic logic signed [AW-1:0] sat(input logic signed [WW-1:0] v);
    return v > S_MAX ? AW'(S_MAX) : v < S_MIN ? AW'(S_MIN) : AW'(v);
  endfunction

  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;

  // sequencing: SUM over every input, then coefficient fetch and the three integrator updates, mix, output
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = s.start ? SUM : IDLE;
      SUM: state_n = idx == I_LAST ? COEF : SUM;
      COEF: state_n = BP;
      BP: state_n = LP;
      LP: state_n = HP;
      HP: state_n = MIX;
      MIX: state_n = OUT;
      OUT: state_n = ch == C_LAST ? IDLE : SUM;
      default: state_n = IDLE;
    endcase
  end

  // shared datapath: operand selection for the current channel plus full-width products before shifting
  always_comb begin
    cur = idx == I_LAST ? ext_s[int'(ch)*DW +: DW] : voice_s[(int'(ch)*VOICES + int'(idx))*DW +: DW];
    xa = AW'(cur) <<< 2;
    rt = route_s[int'(ch)*NI + int'(idx)];
    nf_skip = voff_s[ch] && idx == I_VLAST;
    fc_c = fc_s[int'(ch)*11 +: 11];
    res_c = res_s[int'(ch)*4 +: 4];
    vol_c = vol_s[int'(ch)*4 +: 4];
    mode_c = mode_s[int'(ch)*3 +: 3];
    w0_x = WW'(w0);
    q_x = WW'(q);
    vol_x = WW'(vol_c);
    bp_n = sat(WW'(vbp[ch]) - ((w0_x * WW'(vhp[ch])) >>> 19));
    lp_n = sat(WW'(vlp[ch]) - ((w0_x * WW'(vbp[ch])) >>> 19));
    hp_n = sat(((WW'(vbp[ch]) * q_x) >>> 10) - WW'(vlp[ch]) - WW'(vi));
    vf_n = sat((mode_c[0] ? WW'(vlp[ch]) : ZW) + (mode_c[1] ? WW'(vbp[ch]) : ZW) + (mode_c[2] ? WW'(vhp[ch]) : ZW));
    y_n = fen_s ? sat(WW'(vnf) - WW'(vf_n)) : sat(WW'(vnf) + WW'(vi));
    snd_n = sat((WW'(y) * vol_x) >>> 3);
  end

  // input snapshot, accumulation, integrator updates and per-channel output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
      idx <= '0;
      vi <= '0;
      vnf <= '0;
      y <= '0;
      w0 <= '0;
      q <= '0;
      sound_r <= '0;
      valid_r <= '0;
      ovr_r <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        vhp[c] <= '0;
        vbp[c] <= '0;
        vlp[c] <= '0;
      end
    end else begin
      ovr_r <= s.start && state != IDLE;
      valid_r <= '0;
      if (state == IDLE && s.start) begin
        voice_s <= s.voice_in;
        ext_s <= s.ext_in;
        fc_s <= s.fc;
        res_s <= s.res;
        route_s <= s.route;
        mode_s <= s.mode;
        voff_s <= s.voff;
        vol_s <= s.vol;
        fen_s <= s.filter_en;
        ch <= '0;
        idx <= '0;
      end
      if (state == SUM) begin
        idx <= idx + 1'b1;
        vi <= (idx == '0 ? '0 : vi) + (rt ? xa : '0);
        vnf <= (idx == '0 ? '0 : vnf) + (!rt && !nf_skip ? xa : '0);
      end
      if (state == COEF) begin
        w0 <= 17'((32'd82355 * (32'(fc_c) + 32'd1)) >> 12);
        q <= QT[res_c];
      end
      if (state == BP) vbp[ch] <= bp_n;
      if (state == LP) vlp[ch] <= lp_n;
      if (state == HP) vhp[ch] <= hp_n;
      if (state == MIX) y <= y_n;
      if (state == OUT) begin
        sound_r[int'(ch)*AW +: AW] <= snd_n;
        valid_r[ch] <= 1'b1;
        ch <= ch + 1'b1;
        idx <= '0;
      end
    end
  end

  assign s.busy = state != IDLE;
  assign s.overrun = ovr_r;
  assign s.sound = sound_r;
  assign s.sound_valid = valid_r;
endmodule

// File: tb/tb_sid_svf_multi.sv
// tb_sid_svf_multi: randomized frames checked cycle by cycle against a behavioural filter model
module tb_sid_svf_multi;
  localparam int C = 2, V = 3, DW = 12, AW = 18, NI = V + 1, FL = V + 7, N = C * FL;
  localparam longint SMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  sid_svf_multi_if #(.CHANNELS(C), .VOICES(V), .DW(DW), .AW(AW)) bus ();
  sid_svf_multi #(.CHANNELS(C), .VOICES(V), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .s(bus.slave));
  int checks = 0, passed = 0;
  int qt [16] = '{1448, 1328, 1218, 1117, 1024, 939, 861, 790, 724, 664, 609, 558, 512, 470, 431, 395};
  longint m_hp [C], m_bp [C], m_lp [C], m_snd [C], nxt_snd [C];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  function automatic longint sat(input longint v);
    return v > SMAX ? SMAX : v < SMIN ? SMIN : v;
  endfunction

  function automatic longint vin(input int c, input int i);
    return i < V ? longint'($signed(bus.voice_in[(c*V+i)*DW +: DW])) : longint'($signed(bus.ext_in[c*DW +: DW]));
  endfunction

  function automatic longint snd(input int c);
    return longint'($signed(bus.sound[c*AW +: AW]));
  endfunction

  task automatic model_clear();
    for (int c = 0; c < C; c++) begin
      m_hp[c] = 0; m_bp[c] = 0; m_lp[c] = 0; m_snd[c] = 0; nxt_snd[c] = 0;
    end
  endtask

  task automatic model_frame();
    for (int c = 0; c < C; c++) begin
      longint vi = 0, vnf = 0, x, w0, q, vf, y;
      logic [2:0] md;
      md = bus.mode[c*3 +: 3];
      for (int i = 0; i <= V; i++) begin
        x = vin(c, i) * 4;
        if (bus.route[c*NI+i]) vi += x;
        else if (!(i == V - 1 && bus.voff[c])) vnf += x;
      end
      w0 = (82355 * (longint'(bus.fc[c*11 +: 11]) + 1)) >> 12;
      q = qt[bus.res[c*4 +: 4]];
      m_bp[c] = sat(m_bp[c] - ((w0 * m_hp[c]) >>> 19));
      m_lp[c] = sat(m_lp[c] - ((w0 * m_bp[c]) >>> 19));
      m_hp[c] = sat(((m_bp[c] * q) >>> 10) - m_lp[c] - vi);
      vf = sat((md[0] ? m_lp[c] : 0) + (md[1] ? m_bp[c] : 0) + (md[2] ? m_hp[c] : 0));
      y = bus.filter_en ? sat(vnf - vf) : sat(vnf + vi);
      nxt_snd[c] = sat((y * longint'(bus.vol[c*4 +: 4])) >>> 3);
    end
  endtask

  task automatic set_zero();
    bus.voice_in = '0; bus.ext_in = '0; bus.fc = '0; bus.res = '0; bus.route = '0;
    bus.mode = '0; bus.voff = '0; bus.vol = '0; bus.filter_en = 1'b1;
  endtask

  task automatic rand_ch(input int c);
    for (int v = 0; v < V; v++) bus.voice_in[(c*V+v)*DW +: DW] = DW'($urandom);
    bus.ext_in[c*DW +: DW] = DW'($urandom);
    bus.fc[c*11 +: 11] = 11'($urandom);
    bus.res[c*4 +: 4] = 4'($urandom);
    bus.route[c*NI +: NI] = NI'($urandom);
    bus.mode[c*3 +: 3] = 3'($urandom);
    bus.voff[c] = 1'($urandom);
    bus.vol[c*4 +: 4] = 4'($urandom);
  endtask

  task automatic rand_all();
    for (int c = 0; c < C; c++) rand_ch(c);
    bus.filter_en = 1'($urandom);
  endtask

  task automatic frame(input int ovr_at, input int rst_at, input bit scramble);
    bit aborted = 0;
    logic [C-1:0] vmask;
    bus.start = 1'b1;
    @(posedge clk);
    model_frame();
    #1 bus.start = 1'b0;
    if (scramble) rand_all();
    for (int n = 1; n <= N + 1; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (rst_at > 0 && n == rst_at + 1) rst = 1'b0;
      vmask = '0;
      for (int c = 0; c < C; c++)
        if (!aborted && n == (c + 1) * FL + 1) begin
          m_snd[c] = nxt_snd[c];
          vmask[c] = 1'b1;
        end
      chk("busy", bus.busy, !aborted && n <= N);
      chk("sound_valid", bus.sound_valid, vmask);
      chk("overrun", bus.overrun, ovr_at > 0 && n == ovr_at + 1);
      for (int c = 0; c < C; c++) chk($sformatf("sound%0d", c), snd(c), m_snd[c]);
      if (n == ovr_at) bus.start = 1'b1;
      if (n == rst_at) begin
        rst = 1'b1;
        aborted = 1;
        model_clear();
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    set_zero();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_valid", bus.sound_valid, 0);
    for (int c = 0; c < C; c++) chk("rst_sound", snd(c), 0);
    frame(0, 0, 0);
    bus.filter_en = 1'b0;
    bus.voice_in[DW-1:0] = DW'(100);
    bus.vol[3:0] = 4'd8;
    for (int f = 0; f < 3; f++) begin
      frame(0, 0, 0);
      chk("bypass", snd(0), 400);
      chk("isolation", snd(1), 0);
    end
    rand_all();
    frame(5, 0, 0);
    for (int f = 0; f < 150; f++) begin
      rand_all();
      frame(0, 0, f[0]);
    end
    rand_all();
    frame(0, 12, 0);
    set_zero();
    frame(0, 0, 0);
    chk("post_rst0", snd(0), 0);
    chk("post_rst1", snd(1), 0);
    bus.fc[10:0] = 11'd2047;
    bus.route[0] = 1'b1;
    bus.mode[2:0] = 3'b001;
    bus.voice_in[DW-1:0] = DW'(500);
    bus.vol[3:0] = 4'd8;
    for (int f = 0; f < 3000; f++) frame(0, 0, 0);
    chk("lp_dc_near_2000", snd(0) >= 1984 && snd(0) <= 2016, 1);
    chk("lp_isolation", snd(1), 0);
    for (int c = 0; c < C; c++) begin
      bus.fc[c*11 +: 11] = 11'd2047;
      bus.res[c*4 +: 4] = 4'd15;
      bus.mode[c*3 +: 3] = 3'b010;
      bus.route[c*NI +: NI] = '1;
      bus.vol[c*4 +: 4] = 4'd15;
      bus.voff[c] = 1'b0;
    end
    bus.filter_en = 1'b1;
    for (int f = 0; f < 200; f++) begin
      for (int c = 0; c < C; c++) begin
        for (int v = 0; v < V; v++) bus.voice_in[(c*V+v)*DW +: DW] = DW'(f[2] ? 2047 : -2047);
        bus.ext_in[c*DW +: DW] = DW'(f[2] ? 2047 : -2047);
      end
      frame(0, 0, 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
